multi_button_debouncer: RTL
===========================

// Module: multi_button_debouncer
// PURPOSE
//   Parametrised multi-channel debouncer for raw push-button or switch inputs.
//   Each channel has an input synchroniser and debounces both edges symmetrically.
//   Each channel emits its debounced level, one-cycle press and release pulses,
//   and a one-shot long-press pulse.
//   The block sits between the board pins and the user-input / control logic.
// PARAMETERS
//   NUM_BTNS            4      number of independent channels (>=1)
//   DEBOUNCE_CLK_CNT    65536  cycles a new level must be stable before acceptance (>=1)
//   SYNC_STAGES         2      synchroniser flops per channel (>=2)
//   LONG_PRESS_CLK_CNT  0      cycles held before btn_long pulses; 0 disables long-press
//   ACTIVE_LOW          0      1: a raw input of 0 means pressed (inverted before sync)
// PORTS
//   clk            in   1         system clock; all flops on posedge
//   reset_n        in   1         asynchronous, active-low reset
//   btn_in         in   NUM_BTNS  raw asynchronous button inputs
//   btn_debounced  out  NUM_BTNS  debounced level, 1 = pressed
//   btn_press      out  NUM_BTNS  one-cycle pulse on accepted 0->1
//   btn_release    out  NUM_BTNS  one-cycle pulse on accepted 1->0
//   btn_long       out  NUM_BTNS  one-cycle pulse once per press after long hold
//   any_pressed    out  1         combinational OR of btn_debounced
// BEHAVIOUR
// - Reset (reset_n=0, async): clears all sync flops, counters, and outputs to 0.
//   Everything then reads as "released".
// - Input path: raw = ACTIVE_LOW ? ~btn_in : btn_in.
//   raw passes through SYNC_STAGES flops; s = last stage output.
// - Debounce counter per channel:
//   - Width CW = (DEBOUNCE_CLK_CNT>1) ? $clog2(DEBOUNCE_CLK_CNT) : 1.
//   - When s == btn_debounced: cnt <= 0.
//   - When s != btn_debounced and cnt < DEBOUNCE_CLK_CNT-1: cnt <= cnt+1.
//   - When s != btn_debounced and cnt == DEBOUNCE_CLK_CNT-1:
//     btn_debounced <= s and cnt <= 0.
//   - Result: a change is accepted only after DEBOUNCE_CLK_CNT consecutive differing samples.
//   - Any sample equal to the current level restarts the count.
//   - Compare with ==, never <; cnt never wraps.
// - Latency: a raw edge that then stays stable reaches btn_debounced exactly
//   SYNC_STAGES + DEBOUNCE_CLK_CNT clock edges later.
//   With DEBOUNCE_CLK_CNT=1 the latency is SYNC_STAGES+1.
// - btn_press / btn_release:
//   - Registered; high for exactly one cycle.
//   - Asserted on the same edge btn_debounced changes.
//   - Never both high together on one channel.
// - Long press, per-channel hold counter:
//   - Width $clog2(LONG_PRESS_CLK_CNT+1).
//   - Cleared while btn_debounced=0.
//   - Increments while btn_debounced=1 and saturates at LONG_PRESS_CLK_CNT.
//   - btn_long pulses for one cycle on the edge the counter reaches LONG_PRESS_CLK_CNT.
//   - Exactly once per press; never if released earlier.
//   - A release and re-press requires a fresh full hold.
//   - LONG_PRESS_CLK_CNT=0: btn_long is tied 0 and no hold counters are generated.
// - Channels are fully independent.
//   Simultaneous events on several channels each produce their own pulses on the same cycle.
// - Reset mid-count discards all progress.
//   After reset_n rises, a held button is re-detected with full latency.
// - No state depends on any other input.
//   A button held through reset release yields a press after the full latency.
// TESTING  (NUM_BTNS=4, DEBOUNCE_CLK_CNT=8, SYNC_STAGES=2, LONG_PRESS_CLK_CNT=32)
// 1. Clean press: btn_in[0] 0->1 and held ->
//    btn_debounced[0] rises exactly 10 edges later; btn_press[0] is high 1 cycle on that edge.
//    Other channels stay 0; any_pressed=1.
// 2. Bounce: btn_in[1] toggles every 3 cycles for 30 cycles, then holds 1 ->
//    no pulse during the bounce; btn_press[1] occurs 10 edges after the last toggle.
// 3. Glitch rejection on a held button:
//    btn_in[0] low for 7 cycles -> no btn_release[0].
//    btn_in[0] low for 8+ cycles -> btn_release[0] 10 edges after the falling edge.
// 4. Long press: hold ch2 for 60 cycles ->
//    a single btn_long[2] pulse 32 edges after btn_press[2].
//    Release at 20 cycles -> no btn_long[2].
// 5. Simultaneous + polarity: ch0 and ch3 pressed on the same cycle ->
//    both btn_press pulses on the same edge.
//    An ACTIVE_LOW=1 instance, btn_in 1->0 -> press pulse.
// 6. Reset mid-operation: reset_n=0 with cnt=5 -> all outputs 0 immediately (async).
//    Input still held -> press 10 edges after reset_n rises.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer: per-channel synchroniser, symmetric
// debounce counter, registered press/release pulses and a one-shot long-press pulse.

module mbd_channel #(
    parameter int DEBOUNCE_CLK_CNT   = 65536,
    parameter int SYNC_STAGES        = 2,
    parameter int LONG_PRESS_CLK_CNT = 0,
    parameter int ACTIVE_LOW         = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic deb_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int CW = (DEBOUNCE_CLK_CNT > 1) ? $clog2(DEBOUNCE_CLK_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLK_CNT - 1);

    logic                   raw;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;

    // Polarity is normalised before the synchroniser so all state means "1 = pressed".
    assign raw = (ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;
    assign s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Any sample matching the current level restarts the count; equality test means no wrap.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d   = s;
                press_d = s;
                rel_d   = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign deb_o     = deb_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

    generate
        if (LONG_PRESS_CLK_CNT > 0) begin : g_long
            localparam int LW = $clog2(LONG_PRESS_CLK_CNT + 1);
            localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_PRESS_CLK_CNT);
            localparam logic [LW-1:0] HOLD_PRE = LW'(LONG_PRESS_CLK_CNT - 1);

            logic [LW-1:0] hold_q, hold_d;
            logic          long_q, long_d;

            // Saturating hold counter; the pulse fires only on the step into saturation.
            always_comb begin
                hold_d = '0;
                long_d = 1'b0;
                if (deb_q) begin
                    hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                    long_d = (hold_q == HOLD_PRE);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                end
            end

            assign long_o = long_q;
        end else begin : g_no_long
            assign long_o = 1'b0;
        end
    endgenerate
endmodule

module multi_button_debouncer #(
    parameter int NUM_BTNS           = 4,
    parameter int DEBOUNCE_CLK_CNT   = 65536,
    parameter int SYNC_STAGES        = 2,
    parameter int LONG_PRESS_CLK_CNT = 0,
    parameter int ACTIVE_LOW         = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_debounced,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_long,
    output logic                any_pressed
);
    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
            mbd_channel #(
                .DEBOUNCE_CLK_CNT  (DEBOUNCE_CLK_CNT),
                .SYNC_STAGES       (SYNC_STAGES),
                .LONG_PRESS_CLK_CNT(LONG_PRESS_CLK_CNT),
                .ACTIVE_LOW        (ACTIVE_LOW)
            ) u_ch (
                .clk      (clk),
                .reset_n  (reset_n),
                .btn_raw_i(btn_in[i]),
                .deb_o    (btn_debounced[i]),
                .press_o  (btn_press[i]),
                .release_o(btn_release[i]),
                .long_o   (btn_long[i])
            );
        end
    endgenerate

    assign any_pressed = |btn_debounced;
endmodule
